scoreboard_hazard_unit: RTL and testbench

Parametrised successor to the decode hazard logic. It replaces per-stage destination compares with a register scoreboard, so instructions may complete out of order. The block tracks fixed-latency results with per-register countdowns and variable-latency results (memory) with busy bits. It also reserves the shared fixed-latency writeback slot and stalls decode/fetch on RAW, WAW, writeback-port conflicts, outstanding-limit overflow, barriers, or a backend freeze.

---
 rtl/scoreboard_hazard_unit.sv | 170 +++++++++++++++++
 tb/tb_scoreboard_hazard_unit.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/scoreboard_hazard_unit.sv
// scoreboard_hazard_unit
//   Register scoreboard for decode hazard detection with out-of-order
//   completion. Fixed-latency results are tracked by per-register
//   countdowns plus a writeback-slot reservation vector; variable-latency
//   results (loads) are tracked by busy bits and an outstanding count.
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   dec_valid_i             decode holds a valid instruction
//   rs1/rs2_needed_i, rs1/rs2_i   source operands
//   rd_wr_en_i, rd_i        destination write
//   is_var_lat_i, lat_i     variable-latency flag / fixed latency
//   is_barrier_i            issue only with an empty scoreboard
//   freeze_i                backend stall, freezes fixed pipeline
//   wb_valid_i, wb_reg_i    variable-latency writeback
//   stall_decode_o, stall_fetch_o, bubble_o   stall (all identical)
//   issue_o                 instruction leaves decode this cycle
//   hazard_cause_o          0 none,1 freeze,2 RAW,3 WAW,4 WB,5 full,6 barrier
//   outstanding_o           in-flight variable-latency writers
//   err_o                   sticky writeback-to-idle-register error
module scoreboard_hazard_unit #(
  parameter int unsigned REGISTER_WIDTH  = 5,
  parameter int unsigned MAX_LATENCY     = 8,
  parameter int unsigned LAT_WIDTH       = $clog2(MAX_LATENCY + 1),
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter bit          BYPASS_LAST     = 1'b1
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic                                   dec_valid_i,
  input  logic                                   rs1_needed_i,
  input  logic                                   rs2_needed_i,
  input  logic [REGISTER_WIDTH-1:0]              rs1_i,
  input  logic [REGISTER_WIDTH-1:0]              rs2_i,
  input  logic                                   rd_wr_en_i,
  input  logic [REGISTER_WIDTH-1:0]              rd_i,
  input  logic                                   is_var_lat_i,
  input  logic [LAT_WIDTH-1:0]                   lat_i,
  input  logic                                   is_barrier_i,
  input  logic                                   freeze_i,
  input  logic                                   wb_valid_i,
  input  logic [REGISTER_WIDTH-1:0]              wb_reg_i,
  output logic                                   stall_decode_o,
  output logic                                   stall_fetch_o,
  output logic                                   bubble_o,
  output logic                                   issue_o,
  output logic [2:0]                             hazard_cause_o,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o,
  output logic                                   err_o
);

  localparam int unsigned NUM_REGS = 2 ** REGISTER_WIDTH;
  localparam int unsigned OUT_W    = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [MAX_LATENCY:0] RES_ONE = {{MAX_LATENCY{1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    CAUSE_NONE    = 3'd0,
    CAUSE_FREEZE  = 3'd1,
    CAUSE_RAW     = 3'd2,
    CAUSE_WAW     = 3'd3,
    CAUSE_WB      = 3'd4,
    CAUSE_FULL    = 3'd5,
    CAUSE_BARRIER = 3'd6
  } cause_e;

  logic [LAT_WIDTH-1:0] cnt_q [NUM_REGS];
  logic [LAT_WIDTH-1:0] cnt_d [NUM_REGS];
  logic [NUM_REGS-1:0]  vbusy_q, vbusy_d;
  logic [MAX_LATENCY:0] res_q, res_d;
  logic [OUT_W-1:0]     outs_q, outs_d;
  logic                 err_q, err_d;

  logic   raw1, raw2, waw, wb_conf, full, barrier, any_busy;
  logic   writer, fix_wr, var_wr, stall, issue;
  logic   wb_hit, var_inc, var_dec;
  cause_e cause;

  // Hazard detection, all from current state
  always_comb begin
    raw1 = rs1_needed_i && (rs1_i != '0) &&
           (vbusy_q[rs1_i] || (cnt_q[rs1_i] > LAT_WIDTH'(1)) ||
            ((cnt_q[rs1_i] == LAT_WIDTH'(1)) && (BYPASS_LAST == 1'b0)));
    raw2 = rs2_needed_i && (rs2_i != '0) &&
           (vbusy_q[rs2_i] || (cnt_q[rs2_i] > LAT_WIDTH'(1)) ||
            ((cnt_q[rs2_i] == LAT_WIDTH'(1)) && (BYPASS_LAST == 1'b0)));

    // A write to r0 is architecturally a no-op: it neither hazards nor reserves
    writer = rd_wr_en_i && (rd_i != '0);
    fix_wr = writer && !is_var_lat_i;
    var_wr = writer && is_var_lat_i;

    waw = writer && (vbusy_q[rd_i] || (cnt_q[rd_i] != '0));
    // Shifting out of range yields zero, so oversize latencies never match
    wb_conf = fix_wr && ((res_q & (RES_ONE << lat_i)) != '0);
    full = var_wr && (outs_q == OUT_W'(MAX_OUTSTANDING));

    any_busy = (vbusy_q != '0) || (res_q != '0);
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      if (cnt_q[r] != '0) any_busy = 1'b1;
    end
    barrier = is_barrier_i && any_busy;

    cause = CAUSE_NONE;
    if (freeze_i)          cause = CAUSE_FREEZE;
    else if (dec_valid_i) begin
      if (raw1 || raw2)    cause = CAUSE_RAW;
      else if (waw)        cause = CAUSE_WAW;
      else if (wb_conf)    cause = CAUSE_WB;
      else if (full)       cause = CAUSE_FULL;
      else if (barrier)    cause = CAUSE_BARRIER;
    end

    stall = (cause != CAUSE_NONE);
    issue = dec_valid_i && !stall;
  end

  // Scoreboard next state
  always_comb begin
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      cnt_d[r] = cnt_q[r];
      if (!freeze_i && (cnt_q[r] != '0)) cnt_d[r] = cnt_q[r] - LAT_WIDTH'(1);
    end
    res_d   = freeze_i ? res_q : (res_q >> 1);
    vbusy_d = vbusy_q;
    err_d   = err_q;

    wb_hit  = wb_valid_i && vbusy_q[wb_reg_i];
    var_dec = wb_hit;
    var_inc = issue && var_wr;
    if (wb_hit)                   vbusy_d[wb_reg_i] = 1'b0;
    else if (wb_valid_i)          err_d = 1'b1;

    if (issue && fix_wr) begin
      cnt_d[rd_i] = lat_i;
      // Reservation lands one below the latency because the vector shifts this edge
      if (lat_i != '0) res_d = res_d | (RES_ONE << (lat_i - LAT_WIDTH'(1)));
    end
    // Set after clear so a same-register issue wins over the writeback
    if (var_inc) vbusy_d[rd_i] = 1'b1;

    outs_d = outs_q;
    if (var_inc && !var_dec)      outs_d = outs_q + OUT_W'(1);
    else if (var_dec && !var_inc) outs_d = outs_q - OUT_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned r = 0; r < NUM_REGS; r++) cnt_q[r] <= '0;
      vbusy_q <= '0;
      res_q   <= '0;
      outs_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      for (int unsigned r = 0; r < NUM_REGS; r++) cnt_q[r] <= cnt_d[r];
      vbusy_q <= vbusy_d;
      res_q   <= res_d;
      outs_q  <= outs_d;
      err_q   <= err_d;
    end
  end

  assign stall_decode_o = stall;
  assign stall_fetch_o  = stall;
  assign bubble_o       = stall;
  assign issue_o        = issue;
  assign hazard_cause_o = cause;
  assign outstanding_o  = outs_q;
  assign err_o          = err_q;

endmodule

// File: tb/tb_scoreboard_hazard_unit.sv
module tb_scoreboard_hazard_unit;

  localparam int RW  = 5;
  localparam int ML  = 8;
  localparam int LW  = $clog2(ML + 1);
  localparam int MO  = 4;
  localparam bit BYP = 1'b1;
  localparam int NR  = 2 ** RW;
  localparam int OW  = $clog2(MO + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, dec_valid, rs1_needed, rs2_needed, rd_wr_en;
  logic [RW-1:0] rs1, rs2, rd, wb_reg;
  logic          is_var, is_barrier, freeze, wb_valid;
  logic [LW-1:0] lat;
  logic          stall_decode_o, stall_fetch_o, bubble_o, issue_o, err_o;
  logic [2:0]    hazard_cause_o;
  logic [OW-1:0] outstanding_o;

  scoreboard_hazard_unit #(
    .REGISTER_WIDTH(RW), .MAX_LATENCY(ML), .LAT_WIDTH(LW),
    .MAX_OUTSTANDING(MO), .BYPASS_LAST(BYP)
  ) dut (
    .clk_i(clk), .rst_i(rst), .dec_valid_i(dec_valid),
    .rs1_needed_i(rs1_needed), .rs2_needed_i(rs2_needed),
    .rs1_i(rs1), .rs2_i(rs2), .rd_wr_en_i(rd_wr_en), .rd_i(rd),
    .is_var_lat_i(is_var), .lat_i(lat), .is_barrier_i(is_barrier),
    .freeze_i(freeze), .wb_valid_i(wb_valid), .wb_reg_i(wb_reg),
    .stall_decode_o(stall_decode_o), .stall_fetch_o(stall_fetch_o),
    .bubble_o(bubble_o), .issue_o(issue_o), .hazard_cause_o(hazard_cause_o),
    .outstanding_o(outstanding_o), .err_o(err_o)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: remaining cycles per register, load-busy flags,
  // and a list of pending fixed writebacks as "cycles from now".
  int cnt_m [NR];
  bit vb_m  [NR];
  int pend_q [$];
  int outs_m;
  bit err_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit m_raw(input bit need, input int s);
    return need && s != 0 && (vb_m[s] || cnt_m[s] > 1 || (cnt_m[s] == 1 && !BYP));
  endfunction

  function automatic int m_cause();
    bit wr, busy, slot;
    wr = rd_wr_en && rd != 0;
    busy = pend_q.size() != 0;
    for (int r = 0; r < NR; r++) if (cnt_m[r] != 0 || vb_m[r]) busy = 1;
    slot = 0;
    foreach (pend_q[i]) if (pend_q[i] == int'(lat)) slot = 1;
    if (freeze) return 1;
    if (!dec_valid) return 0;
    if (m_raw(rs1_needed, int'(rs1)) || m_raw(rs2_needed, int'(rs2))) return 2;
    if (wr && (vb_m[rd] || cnt_m[rd] != 0)) return 3;
    if (wr && !is_var && slot) return 4;
    if (wr && is_var && outs_m == MO) return 5;
    if (is_barrier && busy) return 6;
    return 0;
  endfunction

  task automatic model_clear();
    for (int r = 0; r < NR; r++) begin cnt_m[r] = 0; vb_m[r] = 0; end
    pend_q.delete();
    outs_m = 0;
    err_m = 0;
  endtask

  task automatic idle();
    rst = 0; dec_valid = 0; rs1_needed = 0; rs2_needed = 0; rs1 = '0; rs2 = '0;
    rd_wr_en = 0; rd = '0; is_var = 0; lat = LW'(1); is_barrier = 0;
    freeze = 0; wb_valid = 0; wb_reg = '0;
  endtask

  // Called after inputs are driven (just after a falling edge); checks the
  // combinational outputs, then advances the model across the rising edge.
  task automatic cyc();
    int c;
    bit st, iss, wr;
    int tmp [$];
    #1;
    c   = m_cause();
    st  = (c != 0);
    iss = dec_valid && !st;
    chk("stall_decode", stall_decode_o, st);
    chk("stall_fetch", stall_fetch_o, st);
    chk("bubble", bubble_o, st);
    chk("issue", issue_o, iss);
    chk("cause", hazard_cause_o, c);
    chk("outstanding", outstanding_o, outs_m);
    chk("err", err_o, err_m);
    @(posedge clk);
    if (rst) model_clear();
    else begin
      wr = rd_wr_en && rd != 0;
      if (wb_valid) begin
        if (vb_m[wb_reg]) begin vb_m[wb_reg] = 0; outs_m--; end
        else err_m = 1;
      end
      if (!freeze) begin
        for (int r = 0; r < NR; r++) if (cnt_m[r] > 0) cnt_m[r]--;
        foreach (pend_q[i]) if (pend_q[i] > 0) tmp.push_back(pend_q[i] - 1);
        pend_q = tmp;
      end
      if (iss && wr && !is_var) begin
        cnt_m[rd] = int'(lat);
        pend_q.push_back(int'(lat) - 1);
      end
      if (iss && wr && is_var) begin
        vb_m[rd] = 1;
        outs_m++;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    int busy_list [$];
    model_clear();
    idle();
    rst = 1;
    @(negedge clk);
    cyc(); cyc();
    rst = 0;
    cyc();

    // Fixed producer then dependent reader
    dec_valid = 1; rd_wr_en = 1; rd = 5'd5; lat = LW'(3); cyc();
    rd_wr_en = 0; rs1_needed = 1; rs1 = 5'd5;
    repeat (4) cyc();
    idle(); repeat (4) cyc();

    // Two fixed writers aiming at the same writeback slot
    dec_valid = 1; rd_wr_en = 1; rd = 5'd6; lat = LW'(3); cyc();
    rd = 5'd7; lat = LW'(2); cyc(); cyc();
    idle(); repeat (4) cyc();

    // Fill outstanding loads, then a fifth
    dec_valid = 1; rd_wr_en = 1; is_var = 1;
    for (int r = 1; r <= 4; r++) begin rd = RW'(r); cyc(); end
    rd = 5'd5; cyc();
    wb_valid = 1; wb_reg = 5'd2; cyc();
    wb_valid = 0; cyc();
    idle(); cyc();

    // Freeze with a fixed countdown pending and a concurrent load writeback
    dec_valid = 1; rd_wr_en = 1; rd = 5'd7; lat = LW'(2); cyc();
    idle(); freeze = 1; wb_valid = 1; wb_reg = 5'd3; cyc();
    wb_valid = 0; cyc();
    dec_valid = 1; rs1_needed = 1; rs1 = 5'd7; cyc();
    idle(); cyc(); cyc();

    // WAW on an in-flight load, then barrier drained by writebacks
    dec_valid = 1; rd_wr_en = 1; rd = 5'd4; lat = LW'(1); cyc();
    idle(); dec_valid = 1; is_barrier = 1; cyc();
    wb_valid = 1; wb_reg = 5'd1; cyc();
    wb_reg = 5'd4; cyc();
    wb_reg = 5'd5; cyc();
    wb_valid = 0; cyc();
    idle(); cyc();

    // Writeback to an idle register sets a sticky error
    wb_valid = 1; wb_reg = 5'd9; cyc();
    idle(); repeat (3) cyc();
    rst = 1; cyc();
    rst = 0; cyc();

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      idle();
      if (i % 250 == 249) rst = 1;
      dec_valid  = ($urandom_range(0, 99) < 80);
      rs1_needed = $urandom_range(0, 1);
      rs2_needed = $urandom_range(0, 1);
      rs1        = RW'($urandom_range(0, 7));
      rs2        = RW'($urandom_range(0, 7));
      rd_wr_en   = ($urandom_range(0, 99) < 70);
      rd         = RW'($urandom_range(0, 7));
      is_var     = ($urandom_range(0, 99) < 30);
      lat        = LW'($urandom_range(1, ML));
      is_barrier = ($urandom_range(0, 99) < 5);
      freeze     = ($urandom_range(0, 99) < 6);
      busy_list.delete();
      for (int r = 0; r < NR; r++) if (vb_m[r]) busy_list.push_back(r);
      if (busy_list.size() != 0 && $urandom_range(0, 99) < 30) begin
        wb_valid = 1;
        wb_reg   = RW'(busy_list[$urandom_range(0, busy_list.size() - 1)]);
      end else if ($urandom_range(0, 99) < 2) begin
        wb_valid = 1;
        wb_reg   = RW'($urandom_range(0, NR - 1));
      end
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
